cache_csr_ctl: RTL and testbench



---
 rtl/cache_csr_pkg.sv | 15 +
 rtl/cache_csr_if.sv | 30 +++
 rtl/cache_csr_ctl_rd_strobe.sv | 36 +++
 rtl/cache_csr_ctl.sv | 115 +++++++++++
 tb/tb_cache_csr_ctl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_csr_pkg.sv
// Shared definitions for the cache CSR controller: sweep state encoding and CSR bit positions.
package cache_csr_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    CLEAR = 2'd1,
    UP    = 2'd2
  } sweep_state_e;

  localparam int unsigned CSR_EN_BIT  = 0;
  localparam int unsigned CSR_CLR_BIT = 1;
  localparam int unsigned CSR_WDATA_W = 2;
  localparam int unsigned RD_CNT_W    = 3;

endpackage

// File: rtl/cache_csr_if.sv
// Microcode/tag-RAM facing signal bundle of the cache CSR controller.
interface cache_csr_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic                                  csr_wr;
  logic [cache_csr_pkg::CSR_WDATA_W-1:0] csr_wdata;
  logic                                  csr_rd;
  logic                                  mem_gnt;
  logic                                  tag_err;
  logic                                  CUP;
  logic                                  CON;
  logic                                  cache_en;
  logic                                  ECSR_n;
  logic [ADDR_W-1:0]                     clr_addr;
  logic                                  clr_we;
  logic                                  clr_busy;
  logic                                  err_sticky;

  modport master (
    output csr_wr, csr_wdata, csr_rd, mem_gnt, tag_err,
    input  CUP, CON, cache_en, ECSR_n, clr_addr, clr_we, clr_busy, err_sticky
  );

  modport slave (
    input  csr_wr, csr_wdata, csr_rd, mem_gnt, tag_err,
    output CUP, CON, cache_en, ECSR_n, clr_addr, clr_we, clr_busy, err_sticky
  );

endinterface

// File: rtl/cache_csr_ctl_rd_strobe.sv
// Timed active-low CSR read enable: a read request opens a fixed RD_HOLD-cycle window.
module csr_rd_strobe
  import cache_csr_pkg::*;
#(
  parameter int unsigned RD_HOLD = 2
) (
  input  logic sysclk,
  input  logic sys_rst,
  input  logic rd,
  output logic strobe_n
);

  logic [RD_CNT_W-1:0] cnt_q;
  logic [RD_CNT_W-1:0] cnt_d;

  // Requests that land inside an open window are dropped rather than extending it.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (rd) begin
      cnt_d = RD_CNT_W'(RD_HOLD);
    end
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      cnt_q    <= '0;
      strobe_n <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      strobe_n <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/cache_csr_ctl.sv
// Cache CSR controller: owns CUP/CON, runs the tag-invalidate sweep and drives the CSR read strobe.
module cache_csr_ctl
  import cache_csr_pkg::*;
#(
  parameter int unsigned CACHE_ADDR_W = 10,
  parameter int unsigned RD_HOLD      = 2
) (
  input  logic        sysclk,
  input  logic        sys_rst,
  cache_csr_if.slave  bus
);

  localparam logic [CACHE_ADDR_W-1:0] ADDR_LAST = '1;

  sweep_state_e            st_q, st_d;
  logic [CACHE_ADDR_W-1:0] addr_q, addr_d;
  logic                    err_q, err_d;
  logic                    con_q, con_d;
  logic                    cup_q, cup_d;
  logic                    busy_q, busy_d;
  logic                    en_q;
  logic                    clr_req;
  logic                    ecsr_n;

  assign clr_req = bus.csr_wr & bus.csr_wdata[CSR_CLR_BIT];

  // Next-state and registered-output decode for the sweep FSM.
  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    err_d  = err_q;
    con_d  = con_q;
    if (bus.csr_wr) begin
      con_d = bus.csr_wdata[CSR_EN_BIT];
    end
    unique case (st_q)
      OFF: begin
        if (clr_req) begin
          st_d   = CLEAR;
          addr_d = '0;
          err_d  = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_req) begin
          addr_d = '0;
          err_d  = 1'b0;
        end else if (bus.mem_gnt) begin
          if (addr_q == ADDR_LAST) begin
            st_d   = UP;
            addr_d = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      UP: begin
        // A clear request outranks a simultaneous parity error.
        if (clr_req) begin
          st_d   = CLEAR;
          addr_d = '0;
          err_d  = 1'b0;
        end else if (bus.tag_err) begin
          st_d  = OFF;
          err_d = 1'b1;
        end
      end
      default: begin
        st_d   = OFF;
        addr_d = '0;
      end
    endcase
    cup_d  = (st_d == UP);
    busy_d = (st_d == CLEAR);
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      st_q   <= OFF;
      addr_q <= '0;
      err_q  <= 1'b0;
      con_q  <= 1'b0;
      cup_q  <= 1'b0;
      busy_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      err_q  <= err_d;
      con_q  <= con_d;
      cup_q  <= cup_d;
      busy_q <= busy_d;
      en_q   <= cup_q & con_q;
    end
  end

  csr_rd_strobe #(
    .RD_HOLD (RD_HOLD)
  ) u_rd_strobe (
    .sysclk   (sysclk),
    .sys_rst  (sys_rst),
    .rd       (bus.csr_rd),
    .strobe_n (ecsr_n)
  );

  assign bus.CUP        = cup_q;
  assign bus.CON        = con_q;
  assign bus.cache_en   = en_q;
  assign bus.ECSR_n     = ecsr_n;
  assign bus.clr_addr   = addr_q;
  assign bus.clr_we     = busy_q;
  assign bus.clr_busy   = busy_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_cache_csr_ctl.sv
// Scoreboard bench for cache_csr_ctl: directed test-plan phases followed by randomized traffic.
module tb_cache_csr_ctl;

  localparam int unsigned AW      = 4;
  localparam int unsigned NENT    = 1 << AW;
  localparam int unsigned RD_HOLD = 2;

  logic sysclk;
  logic sys_rst;

  cache_csr_if #(.ADDR_W(AW)) bus ();

  cache_csr_ctl #(
    .CACHE_ADDR_W (AW),
    .RD_HOLD      (RD_HOLD)
  ) dut (
    .sysclk  (sysclk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  typedef struct {
    logic          cup;
    logic          con;
    logic          en;
    logic          ecsr_n;
    logic [AW-1:0] addr;
    logic          we;
    logic          busy;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: the cache is either off, sweeping (with an index) or up.
  bit m_up, m_clearing, m_con, m_err, m_en;
  int m_idx, m_rd_left;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  always @(posedge sysclk) begin
    exp_t e;
    if (sys_rst) begin
      m_up = 0; m_clearing = 0; m_con = 0; m_err = 0; m_en = 0;
      m_idx = 0; m_rd_left = 0;
    end else begin
      bit en_next;
      bit clr;
      en_next = m_up & m_con;
      clr = bus.csr_wr && bus.csr_wdata[1];
      if (bus.csr_wr) m_con = bus.csr_wdata[0];
      if (clr) begin
        m_clearing = 1; m_up = 0; m_idx = 0; m_err = 0;
      end else if (m_clearing) begin
        if (bus.mem_gnt) begin
          if (m_idx == NENT - 1) begin
            m_clearing = 0; m_up = 1; m_idx = 0;
          end else begin
            m_idx = m_idx + 1;
          end
        end
      end else if (m_up && bus.tag_err) begin
        m_up = 0; m_err = 1;
      end
      if (m_rd_left > 0) m_rd_left = m_rd_left - 1;
      else if (bus.csr_rd) m_rd_left = RD_HOLD;
      m_en = en_next;
    end
    e.cup = m_up; e.con = m_con; e.en = m_en; e.ecsr_n = (m_rd_left == 0);
    e.addr = AW'(m_idx); e.we = m_clearing; e.busy = m_clearing; e.err = m_err;
    exp_q.push_back(e);
  end

  // Monitor: the DUT presents a full status word every cycle.
  always @(negedge sysclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("CUP",        32'(bus.CUP),        32'(e.cup));
      chk("CON",        32'(bus.CON),        32'(e.con));
      chk("cache_en",   32'(bus.cache_en),   32'(e.en));
      chk("ECSR_n",     32'(bus.ECSR_n),     32'(e.ecsr_n));
      chk("clr_addr",   32'(bus.clr_addr),   32'(e.addr));
      chk("clr_we",     32'(bus.clr_we),     32'(e.we));
      chk("clr_busy",   32'(bus.clr_busy),   32'(e.busy));
      chk("err_sticky", 32'(bus.err_sticky), 32'(e.err));
    end
  end

  task automatic cyc(input bit wr, input bit [1:0] wd, input bit rd, input bit gnt, input bit terr);
    bus.csr_wr    = wr;
    bus.csr_wdata = wd;
    bus.csr_rd    = rd;
    bus.mem_gnt   = gnt;
    bus.tag_err   = terr;
    @(posedge sysclk);
    #1;
  endtask

  // Counts cycles with clr_busy high, optionally stalling the grant at one address.
  task automatic run_busy(input int stall_addr, input int stall_n, output int len);
    int stalls;
    len = 0;
    stalls = 0;
    while (bus.clr_busy === 1'b1 && len < 200) begin
      len++;
      if (int'(bus.clr_addr) == stall_addr && stalls < stall_n) begin
        stalls++;
        cyc(0, 2'b00, 0, 0, 0);
      end else begin
        cyc(0, 2'b00, 0, 1, 0);
      end
    end
  endtask

  initial begin
    int len;
    int lowcnt;
    int guard;
    sys_rst = 1'b1;
    cyc(0, 2'b00, 0, 1, 0);
    cyc(0, 2'b00, 0, 1, 0);
    sys_rst = 1'b0;
    repeat (5) cyc(0, 2'b00, 0, 1, 0);
    chk("idle_CUP", 32'(bus.CUP), 32'd0);
    chk("idle_ECSR_n", 32'(bus.ECSR_n), 32'd1);

    // Full sweep with grant held high.
    cyc(1, 2'b11, 0, 1, 0);
    run_busy(-1, 0, len);
    chk("sweep_len", 32'(len), 32'(NENT));
    chk("sweep_CUP", 32'(bus.CUP), 32'd1);
    cyc(0, 2'b00, 0, 1, 0);
    chk("sweep_cache_en", 32'(bus.cache_en), 32'd1);

    // Grant withheld for three cycles at address 7.
    cyc(1, 2'b11, 0, 1, 0);
    run_busy(7, 3, len);
    chk("stall_len", 32'(len), 32'(NENT + 3));
    chk("stall_CUP", 32'(bus.CUP), 32'd1);

    // Parity error in UP, then a clear request.
    cyc(0, 2'b00, 0, 1, 1);
    chk("terr_CUP", 32'(bus.CUP), 32'd0);
    chk("terr_err", 32'(bus.err_sticky), 32'd1);
    chk("terr_CON", 32'(bus.CON), 32'd1);
    cyc(1, 2'b11, 0, 1, 0);
    chk("reclr_err", 32'(bus.err_sticky), 32'd0);
    chk("reclr_addr", 32'(bus.clr_addr), 32'd0);
    chk("reclr_busy", 32'(bus.clr_busy), 32'd1);

    // Restart mid-sweep at address 9.
    guard = 0;
    while (bus.clr_addr !== AW'(9) && guard < 50) begin
      guard++;
      cyc(0, 2'b00, 0, 1, 0);
    end
    chk("reach_addr9", 32'(bus.clr_addr), 32'd9);
    cyc(1, 2'b11, 0, 1, 0);
    chk("restart_addr", 32'(bus.clr_addr), 32'd0);
    run_busy(-1, 0, len);
    chk("restart_len", 32'(len), 32'(NENT));

    // Reset mid-sweep aborts immediately.
    cyc(1, 2'b11, 0, 1, 0);
    repeat (4) cyc(0, 2'b00, 0, 1, 0);
    sys_rst = 1'b1;
    cyc(0, 2'b00, 0, 1, 0);
    sys_rst = 1'b0;
    chk("rst_busy", 32'(bus.clr_busy), 32'd0);
    chk("rst_addr", 32'(bus.clr_addr), 32'd0);
    chk("rst_CUP", 32'(bus.CUP), 32'd0);

    // Read window with a second request inside it.
    cyc(0, 2'b00, 1, 1, 0);
    lowcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ECSR_n === 1'b0) lowcnt++;
      cyc(0, 2'b00, (i == 0), 1, 0);
    end
    chk("rd_low_len", 32'(lowcnt), 32'(RD_HOLD));
    cyc(1, 2'b01, 1, 1, 0);
    chk("rdwr_ECSR_n", 32'(bus.ECSR_n), 32'd0);
    chk("rdwr_CON", 32'(bus.CON), 32'd1);
    repeat (3) cyc(0, 2'b00, 0, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit wr, rd, gnt, terr;
      bit [1:0] wd;
      wr   = ($urandom_range(0, 99) < 6);
      wd   = 2'($urandom_range(0, 3));
      rd   = ($urandom_range(0, 99) < 12);
      gnt  = ($urandom_range(0, 99) < 80);
      terr = ($urandom_range(0, 99) < 5);
      sys_rst = ($urandom_range(0, 999) < 3);
      cyc(wr, wd, rd, gnt, terr);
    end
    sys_rst = 1'b0;
    repeat (3) cyc(0, 2'b00, 0, 1, 0);
    @(negedge sysclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
